mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_starve_counter.sv | 25 ++
 rtl/mem_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the CPU/VGA memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } owner_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 15;

  // Counter width able to hold 0..max inclusive.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction
endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive refused VGA cycles; clr has priority over inc.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int             W     = cnt_w(MAX);
  localparam logic [W-1:0]   MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset)                    r_cnt <= '0;
    else if (clr)                  r_cnt <= '0;
    else if (inc && r_cnt != MAX_V) r_cnt <= r_cnt + 1'b1;
  end

  assign at_max = (r_cnt == MAX_V);
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between a CPU (read/write) and a VGA reader.
// Define MEM_ARB_RR_EN for round-robin contention; default build gives the CPU priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  owner_t r_last_owner;
  owner_t r_tag;
  logic   w_cpu_gnt, w_vga_gnt, w_at_max;

  arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (vga_req & ~w_vga_gnt),
    .clr    (w_vga_gnt | ~vga_req),
    .at_max (w_at_max)
  );

  // Grants are purely combinational so a lone requester is served the cycle it asks.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_vga_gnt = 1'b0;
    if (reset) begin
      if (vga_req && w_at_max) begin
        w_vga_gnt = 1'b1;
      end else if (cpu_req && vga_req) begin
`ifdef MEM_ARB_RR_EN
        if (r_last_owner == OWN_CPU) w_vga_gnt = 1'b1;
        else                         w_cpu_gnt = 1'b1;
`else
        w_cpu_gnt = 1'b1;
`endif
      end else if (cpu_req) begin
        w_cpu_gnt = 1'b1;
      end else if (vga_req) begin
        w_vga_gnt = 1'b1;
      end
    end
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign vga_gnt   = w_vga_gnt;
  assign mem_en    = w_cpu_gnt | w_vga_gnt;
  assign mem_we    = w_cpu_gnt & cpu_we;
  assign mem_addr  = w_cpu_gnt ? cpu_addr : (w_vga_gnt ? vga_addr : '0);
  assign mem_wdata = (w_cpu_gnt && cpu_we) ? cpu_wdata : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_owner <= OWN_VGA;
      r_tag        <= OWN_NONE;
    end else begin
      if (w_cpu_gnt)      r_last_owner <= OWN_CPU;
      else if (w_vga_gnt) r_last_owner <= OWN_VGA;

      if (w_cpu_gnt && !cpu_we) r_tag <= OWN_CPU;
      else if (w_vga_gnt)       r_tag <= OWN_VGA;
      else                      r_tag <= OWN_NONE;
    end
  end

  // Gating with reset kills a read whose data would land during reset.
  assign cpu_rvalid = reset && (r_tag == OWN_CPU);
  assign vga_rvalid = reset && (r_tag == OWN_VGA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign vga_rdata  = vga_rvalid ? mem_rdata : '0;
endmodule
